// File: rtl/set_pkg.sv
// rtl/set_pkg.sv - command record layout, FSM encoding and mode constants shared with SET
package set_pkg;

  // Command record: {mode, central, radius, expected}
  localparam int CMD_W        = 46;
  localparam int CMD_MODE_MSB = 45;
  localparam int CMD_MODE_LSB = 44;
  localparam int CMD_CEN_MSB  = 43;
  localparam int CMD_CEN_LSB  = 20;
  localparam int CMD_RAD_MSB  = 19;
  localparam int CMD_RAD_LSB  = 8;
  localparam int CMD_EXP_MSB  = 7;
  localparam int CMD_EXP_LSB  = 0;

  // SET operating modes; mode 3 is passed through untouched
  localparam logic [1:0] MODE_A   = 2'd0;
  localparam logic [1:0] MODE_AND = 2'd1;
  localparam logic [1:0] MODE_XOR = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_MEM,
    ST_ISSUE,
    ST_WAIT_VALID,
    ST_CHECK,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [1:0]  mode;
    logic [23:0] central;
    logic [11:0] radius;
    logic [7:0]  expected;
  } cmd_t;

  // Split a raw command word into its named fields
  function automatic cmd_t unpack_cmd(input logic [CMD_W-1:0] d);
    cmd_t c;
    c.mode     = d[CMD_MODE_MSB:CMD_MODE_LSB];
    c.central  = d[CMD_CEN_MSB:CMD_CEN_LSB];
    c.radius   = d[CMD_RAD_MSB:CMD_RAD_LSB];
    c.expected = d[CMD_EXP_MSB:CMD_EXP_LSB];
    return c;
  endfunction

endpackage

// File: rtl/set_host_wdog.sv
// rtl/set_host_wdog.sv - watchdog counting cycles spent waiting for a SET result
module set_host_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count;

  // Count from 0 while enabled, park at the limit so expired stays asserted
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/set_host.sv
// rtl/set_host.sv - command-driven initiator and result checker in front of SET
module set_host
  import set_pkg::*;
#(
  parameter int NUM_CMD = 64,
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic [CMD_W-1:0]  cmd_data,
  output logic              en,
  output logic [23:0]       central,
  output logic [11:0]       radius,
  output logic [1:0]        mode,
  input  logic              busy,
  input  logic              valid,
  input  logic [7:0]        candidate,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_addr,
  output logic [7:0]        res_data,
  output logic [ADDR_W:0]   err_cnt,
  output logic              done,
  output logic              pass
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_CMD - 1);
  localparam logic [ADDR_W:0]   ERR_MAX  = '1;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] index;
  logic [7:0]        expected;
  logic [7:0]        cand_q;
  logic              timeout_q;
  logic              expired;
  logic              mismatch;
  cmd_t              cmd;

  assign cmd      = unpack_cmd(cmd_data);
  assign mismatch = (cand_q != expected);

  // The command index doubles as the memory address and result address
  assign cmd_addr = index;
  assign res_addr = index;
  assign res_data = cand_q;
  assign pass     = done && (err_cnt == '0);

  set_host_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != ST_WAIT_VALID),
    .enable  (state == ST_WAIT_VALID),
    .expired (expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and strobe decode; en/res_we/done are pure state decodes so reset drops them at once
  always_comb begin
    state_nxt = state;
    en        = 1'b0;
    res_we    = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        state_nxt = ST_WAIT_MEM;
      end
      ST_WAIT_MEM: begin
        if (!busy) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        en        = 1'b1;
        state_nxt = ST_WAIT_VALID;
      end
      ST_WAIT_VALID: begin
        if (valid || expired) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        res_we    = 1'b1;
        state_nxt = (index == LAST_IDX) ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) state_nxt = ST_FETCH;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath: record capture, result latch, error counting and index stepping
  always_ff @(posedge clk) begin
    if (rst) begin
      index     <= '0;
      central   <= '0;
      radius    <= '0;
      mode      <= '0;
      expected  <= '0;
      cand_q    <= '0;
      timeout_q <= 1'b0;
      err_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            index   <= '0;
            err_cnt <= '0;
          end
        end
        ST_WAIT_MEM: begin
          // Re-captured every stall cycle; address is stable so the data is too
          central  <= cmd.central;
          radius   <= cmd.radius;
          mode     <= cmd.mode;
          expected <= cmd.expected;
        end
        ST_WAIT_VALID: begin
          // A result arriving on the expiry cycle wins over the timeout
          if (valid) begin
            cand_q    <= candidate;
            timeout_q <= 1'b0;
          end else if (expired) begin
            cand_q    <= 8'h00;
            timeout_q <= 1'b1;
          end
        end
        ST_CHECK: begin
          if ((timeout_q || mismatch) && (err_cnt != ERR_MAX)) begin
            err_cnt <= err_cnt + (ADDR_W + 1)'(1);
          end
          if (index != LAST_IDX) begin
            index <= index + ADDR_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_set_host.sv
// tb/tb_set_host.sv - directed self-checking bench for set_host with a behavioural SET
module tb_set_host;

  localparam int NUM_CMD = 3;
  localparam int ADDR_W  = 6;
  localparam int TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] cmd_addr;
  logic [45:0]       cmd_data;
  logic              en;
  logic [23:0]       central;
  logic [11:0]       radius;
  logic [1:0]        mode;
  logic              busy;
  logic              valid;
  logic [7:0]        candidate;
  logic              res_we;
  logic [ADDR_W-1:0] res_addr;
  logic [7:0]        res_data;
  logic [ADDR_W:0]   err_cnt;
  logic              done;
  logic              pass;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  set_host #(
    .NUM_CMD (NUM_CMD),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .en        (en),
    .central   (central),
    .radius    (radius),
    .mode      (mode),
    .busy      (busy),
    .valid     (valid),
    .candidate (candidate),
    .res_we    (res_we),
    .res_addr  (res_addr),
    .res_data  (res_data),
    .err_cnt   (err_cnt),
    .done      (done),
    .pass      (pass)
  );

  // Sync-read command memory
  logic [45:0] cmd_mem [0:63];
  always @(posedge clk) cmd_data <= cmd_mem[cmd_addr];

  // Behavioural SET: valid appears lat_tab+2 cycles after the en cycle
  int          lat_tab  [0:3];
  logic [7:0]  resp_tab [0:3];
  logic        resp_on  [0:3];
  logic        m_pend  = 1'b0;
  int          m_cnt   = 0;
  logic [1:0]  m_idx   = 2'd0;
  logic        m_valid = 1'b0;
  logic [7:0]  m_cand  = 8'h00;
  logic        spur_valid;

  always @(posedge clk) begin
    if (rst) begin
      m_pend  <= 1'b0;
      m_cnt   <= 0;
      m_valid <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if (en) begin
        m_pend <= resp_on[cmd_addr[1:0]];
        m_idx  <= cmd_addr[1:0];
        m_cnt  <= 0;
      end else if (m_pend) begin
        if (m_cnt == lat_tab[m_idx]) begin
          m_valid <= 1'b1;
          m_cand  <= resp_tab[m_idx];
          m_pend  <= 1'b0;
        end
        m_cnt <= m_cnt + 1;
      end
    end
  end

  assign valid     = m_valid | spur_valid;
  assign candidate = m_valid ? m_cand : 8'hEE;

  // Observe strobes mid-cycle: pulse counts, back-to-back en, result memory, en-to-write gap
  int         cyc       = 0;
  int         en_total  = 0;
  int         en_double = 0;
  int         we_total  = 0;
  int         en_cyc    = 0;
  logic       en_prev   = 1'b0;
  logic [7:0] res_mem [0:3];
  int         gap     [0:3];

  always @(negedge clk) begin
    cyc     <= cyc + 1;
    en_prev <= en;
    if (en) begin
      en_total <= en_total + 1;
      en_cyc   <= cyc;
      if (en_prev) en_double <= en_double + 1;
    end
    if (res_we) begin
      we_total                <= we_total + 1;
      res_mem[res_addr[1:0]]  <= res_data;
      gap[res_addr[1:0]]      <= cyc - en_cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      step(1);
      n++;
    end
    check("done_wait", done, 1);
  endtask

  task automatic set_model(input int lat, input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2);
    for (int i = 0; i < 4; i++) begin
      lat_tab[i] = lat;
      resp_on[i] = 1'b1;
    end
    resp_tab[0] = r0;
    resp_tab[1] = r1;
    resp_tab[2] = r2;
    resp_tab[3] = 8'h00;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_en"}, en, 0);
    check({tag, "_res_we"}, res_we, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_cmd_addr"}, cmd_addr, 0);
    check({tag, "_central"}, central, 0);
    check({tag, "_radius"}, radius, 0);
    check({tag, "_mode"}, mode, 0);
    check({tag, "_res_data"}, res_data, 0);
  endtask

  initial begin
    int e0;
    int w0;
    rst        = 1'b1;
    start      = 1'b0;
    busy       = 1'b0;
    spur_valid = 1'b0;
    for (int i = 0; i < 64; i++) cmd_mem[i] = '0;
    for (int i = 0; i < 4; i++) begin
      res_mem[i] = 8'h00;
      gap[i]     = 0;
    end
    cmd_mem[0] = {2'd0, 24'h440000, 12'h300, 8'd29};
    cmd_mem[1] = {2'd1, 24'h123456, 12'hABC, 8'd13};
    cmd_mem[2] = {2'd2, 24'hFEDCBA, 12'h00F, 8'd32};
    set_model(200, 8'd29, 8'd12, 8'd32);

    step(3);
    check_all_zero("reset");
    rst = 1'b0;
    step(2);

    // Run 1: one mismatching record out of three
    e0 = en_total;
    w0 = we_total;
    pulse_start();
    wait_done(2000);
    check("r1_err_cnt", err_cnt, 1);
    check("r1_pass", pass, 0);
    check("r1_res0", res_mem[0], 29);
    check("r1_res1", res_mem[1], 12);
    check("r1_res2", res_mem[2], 32);
    check("r1_en_pulses", en_total - e0, 3);
    check("r1_en_double", en_double, 0);
    check("r1_we_pulses", we_total - w0, 3);
    check("r1_central", central, 24'hFEDCBA);
    check("r1_radius", radius, 12'h00F);
    check("r1_mode", mode, 2);
    step(5);
    check("r1_done_held", done, 1);

    // Run 2: busy stalls the first issue; last record uses mode 3
    cmd_mem[2] = {2'd3, 24'hFEDCBA, 12'h00F, 8'd32};
    set_model(20, 8'd29, 8'd13, 8'd32);
    busy = 1'b1;
    e0   = en_total;
    pulse_start();
    check("r2_done_cleared", done, 0);
    check("r2_err_cleared", err_cnt, 0);
    step(12);
    check("r2_busy_no_en", en_total - e0, 0);
    check("r2_busy_addr", cmd_addr, 0);
    busy = 1'b0;
    wait_done(2000);
    check("r2_err_cnt", err_cnt, 0);
    check("r2_pass", pass, 1);
    check("r2_en_pulses", en_total - e0, 3);
    check("r2_mode3", mode, 3);
    check("r2_res1", res_mem[1], 13);

    // Run 3: valid on the expiry cycle, no response, valid one cycle too late
    set_model(0, 8'd29, 8'd13, 8'd32);
    lat_tab[0] = TIMEOUT - 1;
    resp_on[1] = 1'b0;
    lat_tab[2] = TIMEOUT;
    pulse_start();
    wait_done(3000);
    check("r3_err_cnt", err_cnt, 2);
    check("r3_pass", pass, 0);
    check("r3_res0", res_mem[0], 29);
    check("r3_res1", res_mem[1], 0);
    check("r3_res2", res_mem[2], 0);
    check("r3_gap0", gap[0], TIMEOUT + 2);
    check("r3_gap1", gap[1], TIMEOUT + 2);
    check("r3_gap2", gap[2], TIMEOUT + 2);

    // Run 4: spurious valid in FETCH/WAIT_MEM and a start mid-run are ignored
    set_model(10, 8'd29, 8'd13, 8'd32);
    e0    = en_total;
    start = 1'b1;
    step(1);
    start      = 1'b0;
    spur_valid = 1'b1;
    step(2);
    spur_valid = 1'b0;
    step(4);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done(2000);
    check("r4_err_cnt", err_cnt, 0);
    check("r4_pass", pass, 1);
    check("r4_en_pulses", en_total - e0, 3);
    check("r4_res0", res_mem[0], 29);
    check("r4_res2", res_mem[2], 32);

    // Run 5: reset while waiting on record 1
    set_model(10, 8'd99, 8'd13, 8'd32);
    pulse_start();
    step(22);
    check("r5_pre_err", err_cnt, 1);
    check("r5_pre_addr", cmd_addr, 1);
    rst = 1'b1;
    step(1);
    check_all_zero("r5_rst");
    rst = 1'b0;
    e0  = en_total;
    step(40);
    check("r5_idle_no_en", en_total - e0, 0);
    check("r5_idle_done", done, 0);

    // Run 6: clean restart after reset
    set_model(10, 8'd29, 8'd13, 8'd32);
    e0 = en_total;
    pulse_start();
    wait_done(2000);
    check("r6_err_cnt", err_cnt, 0);
    check("r6_pass", pass, 1);
    check("r6_en_pulses", en_total - e0, 3);
    check("r6_res0", res_mem[0], 29);
    check("r6_res1", res_mem[1], 13);
    check("r6_res2", res_mem[2], 32);
    check("r6_en_double", en_double, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
